vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port framebuffer RAM between VGA scan-out and the processor.
//  Prefetches pixels into a small FIFO that the VGA timing generator pops at pixel rate.
//  Grants leftover memory cycles to the processor's read/write port.
//  Sits between the VGA controller (clk domain, 25 MHz pixel enable) and the framebuffer RAM.
// PARAMETERS
//  DW         8      pixel/data width (grayscale, drives r=g=b)
//  AW         17     framebuffer address width
//  FB_PIXELS  76800  pixels per frame (320x240)
//  FIFO_DEPTH 8      pixel prefetch FIFO entries (power of 2)
//  LOW_WM     3      below this, video fetch is urgent
// PORTS
//  clk         in   1   system clock (50 MHz)
//  reset       in   1   synchronous, active-low reset
//  frame_start in   1   1-cycle pulse before first active pixel of a frame
//  pix_pop     in   1   VGA consumes FIFO head this cycle
//  pix_data    out  DW  FIFO head pixel
//  pix_valid   out  1   FIFO non-empty
//  underrun    out  1   sticky: pix_pop seen while FIFO empty
//  cpu_req     in   1   processor access request (held until cpu_gnt)
//  cpu_we      in   1   1=write, 0=read
//  cpu_addr    in   AW  processor address
//  cpu_wdata   in   DW  processor write data
//  cpu_gnt     out  1   access issued to RAM this cycle
//  cpu_rvalid  out  1   cpu_rdata valid (1 cycle after read grant)
//  cpu_rdata   out  DW  processor read data
//  mem_addr    out  AW  RAM address
//  mem_we      out  1   RAM write enable
//  mem_wdata   out  DW  RAM write data
//  mem_rdata   in   DW  RAM read data, 1-cycle latency
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  - Reset (reset==0 at a clk edge):
//    - pix_data, pix_valid, underrun, cpu_gnt, cpu_rvalid, cpu_rdata, mem_we, mem_addr, mem_wdata = 0.
//    - FIFO empty; video address 0; state IDLE.
//  - FSM:
//    - IDLE: no video fetches. frame_start -> FILL.
//    - FILL: video fetches enabled. Video address reaches FB_PIXELS -> DONE.
//    - DONE: processor only.
//    - frame_start in any state: flushes FIFO, video address := 0, state := FILL.
//  - Credit count = FIFO level + video reads in flight (0..1). Video wants a slot when state==FILL and credits<FIFO_DEPTH.
//  - Arbitration, one RAM access per cycle, decided combinationally:
//    1. Video, if it wants a slot and credits<LOW_WM (urgent).
//    2. Processor, if cpu_req.
//    3. Video, if it wants a slot.
//    4. Idle: mem_we=0, mem_addr holds.
//  - Video grant: mem_addr=video addr, mem_we=0. Video addr increments; credits+1.
//    - Next cycle mem_rdata is pushed into the FIFO unless a flush occurred in between; a dropped read releases its credit.
//  - Processor grant: cpu_gnt=1; mem_addr=cpu_addr; mem_we=cpu_we; mem_wdata=cpu_wdata.
//    - Read: cpu_rvalid=1 next cycle with cpu_rdata=mem_rdata, registered and held until the next read.
//    - Write: no rvalid.
//  - pix_pop with pix_valid: FIFO pops, credits-1. Simultaneous push+pop: level unchanged, data order preserved.
//  - pix_pop with FIFO empty: no pop, underrun:=1. underrun clears only on frame_start or reset.
//  - pix_data shows FIFO head combinationally; 0 when empty.
//  - frame_start with cpu_req pending: processor unaffected, arbitration as above.
//  - frame_start and pix_pop in the same cycle: flush wins, no underrun.
//  - Video addr never exceeds FB_PIXELS-1. No wrap within a frame; frame_start restarts at 0.
// TESTING
//  1. Reset low 2 cycles, release. All outputs 0, no mem access until frame_start.
//  2. Preload RAM[i]=i[7:0]; frame_start, no pops. FIFO fills to 8 with 0..7; exactly 8 video reads, mem_addr 0..7.
//  3. frame_start, then pix_pop every 2nd cycle for 64 pops. pix_data sequence 0..63, underrun stays 0.
//  4. As test 3 plus cpu_req held continuously (writes to 0x10000+k).
//     - cpu_gnt on at least 1 of every 2 cycles; all writes land; underrun 0.
//  5. cpu read of addr 5 (RAM=0xA5) with video idle. cpu_gnt next edge; cpu_rvalid=1, cpu_rdata=0xA5 one cycle later.
//  6. Four pops on an empty FIFO before frame_start. underrun=1; next frame_start clears it, and the FIFO restarts at pixel 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between a VGA pixel prefetch FIFO and a CPU port; arbitration is combinational.
// Video is urgent below LOW_WM credits and otherwise takes leftover slots; the CPU holds cpu_req until cpu_gnt.
module vga_fb_arbiter #(
  parameter int DW         = 8,
  parameter int AW         = 17,
  parameter int FB_PIXELS  = 76800,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WM     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pix_pop,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underrun,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FB_PIXELS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LOW_L     = LW'(LOW_WM);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   vaddr, vaddr_nxt, last_addr;
  logic [DW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level, credits;
  logic            vid_inflight, cpu_rd_pend;
  logic [DW-1:0]   rdata_q;
  logic            vid_want, vid_urgent, vid_gnt, push, pop;

  // Credits count the in-flight read so the FIFO can never be oversubscribed.
  assign credits    = level + LW'(vid_inflight);
  assign vid_want   = reset && (state == FILL) && (credits < DEPTH_L);
  assign vid_urgent = vid_want && (credits < LOW_L);
  assign cpu_gnt    = reset && cpu_req && !vid_urgent;
  assign vid_gnt    = vid_want && !cpu_gnt;

  assign mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vaddr : last_addr);
  assign mem_we    = cpu_gnt && cpu_we;
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  // A read returning during a flush is discarded, which frees its credit.
  assign push      = vid_inflight && !frame_start;
  assign pop       = pix_pop && (level != '0) && !frame_start;
  assign pix_valid = (level != '0);
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;

  assign cpu_rvalid = cpu_rd_pend;
  assign cpu_rdata  = cpu_rd_pend ? mem_rdata : rdata_q;

  always_comb begin
    state_nxt = state;
    vaddr_nxt = vaddr;
    if (vid_gnt) begin
      if (vaddr == LAST_ADDR) state_nxt = DONE;
      else                    vaddr_nxt = vaddr + AW'(1);
    end
    if (frame_start) begin
      state_nxt = FILL;
      vaddr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      vaddr        <= '0;
      last_addr    <= '0;
      vid_inflight <= 1'b0;
      cpu_rd_pend  <= 1'b0;
      rdata_q      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nxt;
      vaddr        <= vaddr_nxt;
      last_addr    <= mem_addr;
      vid_inflight <= vid_gnt && !frame_start;
      cpu_rd_pend  <= cpu_gnt && !cpu_we;
      if (cpu_rd_pend) rdata_q <= mem_rdata;
      if (frame_start) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        level    <= '0;
        underrun <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: ;
        endcase
        if (pix_pop && (level == '0)) underrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: synchronous RAM model, CPU access table, pixel/read scoreboards.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset, frame_start, pix_pop;
  logic [7:0]  pix_data;
  logic        pix_valid, underrun;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  // Synchronous single-port RAM, 1-cycle read latency.
  logic       ram_init;
  logic [7:0] ram [131072];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 131072; i++) ram[i] <= i[7:0];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [7:0]  hold;
  } vec_t;

  int tests = 0, failed = 0;
  logic [7:0]  exp_rdata [$];
  logic [7:0]  exp_pix [$];
  logic [16:0] exp_addr [$];
  logic        trk_addr = 1'b0;
  logic [16:0] prev_addr;
  int          addr_chg;
  logic        t4_on = 1'b0, t4_trk = 1'b0, t4_adv = 1'b0;
  int          k, miss_run, t4_viol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [16:0] ea;
    if (cpu_rvalid) begin
      if (exp_rdata.size() == 0) chk("rvalid_unexpected", 1, 0);
      else chk("cpu_rdata", cpu_rdata, exp_rdata.pop_front());
    end
    if (pix_pop && pix_valid && !frame_start) begin
      if (exp_pix.size() == 0) chk("pix_unexpected", 1, 0);
      else chk("pix_data", pix_data, exp_pix.pop_front());
    end
    if (trk_addr && mem_addr != prev_addr) begin
      addr_chg++;
      prev_addr = mem_addr;
      if (exp_addr.size() == 0) chk("vid_addr_extra", mem_addr, 17'h1ffff);
      else chk("vid_addr", {mem_we, mem_addr}, {1'b0, exp_addr.pop_front()});
    end
    if (t4_on) begin
      if (cpu_gnt) begin
        ea = 17'h10000 + 17'(k);
        chk("t4_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, ea, k[7:0] ^ 8'h5a});
        t4_adv   = 1'b1;
        miss_run = 0;
      end else if (t4_trk) begin
        miss_run++;
        if (miss_run >= 2) t4_viol++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (t4_adv) begin
      t4_adv    = 1'b0;
      k++;
      cpu_addr  = 17'h10000 + 17'(k);
      cpu_wdata = k[7:0] ^ 8'h5a;
    end
  endtask

  initial begin
    vec_t vec [8];
    int   lat, bad;
    logic got;

    vec[0] = '{1'b1, 17'h00005,  8'ha5, 8'h00, 8'h00};
    vec[1] = '{1'b0, 17'h00005,  8'h00, 8'ha5, 8'ha5};
    vec[2] = '{1'b0, 17'h000ff,  8'h00, 8'hff, 8'hff};
    vec[3] = '{1'b1, 17'h1ffff,  8'h3c, 8'h00, 8'hff};
    vec[4] = '{1'b1, 17'h12345,  8'h7e, 8'h00, 8'hff};
    vec[5] = '{1'b0, 17'h12345,  8'h00, 8'h7e, 8'h7e};
    vec[6] = '{1'b0, 17'h00005,  8'h00, 8'ha5, 8'ha5};
    vec[7] = '{1'b0, 17'h1ffff,  8'h00, 8'h3c, 8'h3c};

    reset = 1'b0; frame_start = 1'b0; pix_pop = 1'b0; ram_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset for two edges, then idle with no memory traffic.
    @(posedge clk); #1; ram_init = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pix", {pix_data, pix_valid, underrun}, 0);
    chk("rst_cpu", {cpu_gnt, cpu_rvalid, cpu_rdata}, 0);
    chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we || cpu_gnt || mem_addr != 0 || pix_valid || cpu_rvalid) bad++;
      @(posedge clk); #1;
    end
    chk("idle_no_access", bad, 0);

    // CPU access table, video idle.
    for (int i = 0; i < 8; i++) begin
      cpu_req = 1'b1; cpu_we = vec[i].we; cpu_addr = vec[i].addr; cpu_wdata = vec[i].wdata;
      if (!vec[i].we) exp_rdata.push_back(vec[i].rdata);
      got = 1'b0; lat = 0;
      while (!got && lat < 16) begin
        @(negedge clk);
        monitor();
        if (cpu_gnt) begin
          got = 1'b1;
          chk("tbl_cmd", {mem_we, mem_addr, mem_wdata}, {vec[i].we, vec[i].addr, vec[i].wdata});
        end
        @(posedge clk); #1;
        if (!got) lat++;
      end
      chk("tbl_gnt_lat", lat, 0);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
      step();
      @(negedge clk);
      monitor();
      chk("tbl_hold", {cpu_rvalid, cpu_rdata, mem_we, mem_addr}, {1'b0, vec[i].hold, 1'b0, vec[i].addr});
      @(posedge clk); #1;
    end
    chk("tbl_reads_done", exp_rdata.size(), 0);

    // Fill: exactly eight video reads at 0..7, no pops.
    ram_init = 1'b1; step(); ram_init = 1'b0;
    for (int i = 0; i < 8; i++) exp_addr.push_back(17'(i));
    prev_addr = mem_addr; addr_chg = 0; trk_addr = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    trk_addr = 1'b0;
    chk("fill_reads", addr_chg, 8);
    @(negedge clk);
    chk("fill_head", {pix_valid, pix_data, underrun}, {1'b1, 8'h00, 1'b0});
    @(posedge clk); #1;

    // Pop every second cycle, 64 pixels.
    exp_pix.delete();
    for (int i = 0; i < 64; i++) exp_pix.push_back(i[7:0]);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 64; i++) begin
      pix_pop = 1'b1; step(); pix_pop = 1'b0; step();
    end
    chk("t3_all_popped", exp_pix.size(), 0);
    chk("t3_underrun", underrun, 0);

    // Same with continuous CPU writes competing.
    for (int i = 0; i < 64; i++) exp_pix.push_back(i[7:0]);
    k = 0; miss_run = 0; t4_viol = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h10000; cpu_wdata = 8'h5a; t4_on = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    t4_trk = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pix_pop = 1'b1; step(); pix_pop = 1'b0; step();
    end
    t4_trk = 1'b0; t4_on = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(); step();
    chk("t4_all_popped", exp_pix.size(), 0);
    chk("t4_underrun", underrun, 0);
    chk("t4_gnt_gaps", t4_viol, 0);
    chk("t4_gnt_count", (k >= 64), 1);
    bad = 0;
    for (int j = 0; j < k; j++) if (ram[32'h10000 + j] !== (j[7:0] ^ 8'h5a)) bad++;
    chk("t4_writes_land", bad, 0);

    // Underrun before any frame, cleared by frame_start (coinciding with a pop).
    reset = 1'b0; step(); step(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_pop = 1'b1; step(); pix_pop = 1'b0; step();
    end
    step(); step();
    @(negedge clk);
    chk("t6_underrun_set", {underrun, pix_valid}, {1'b1, 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) exp_pix.push_back(i[7:0]);
    frame_start = 1'b1; pix_pop = 1'b1; step(); frame_start = 1'b0; pix_pop = 1'b0;
    @(negedge clk);
    chk("t6_underrun_clr", underrun, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 4; i++) begin
      pix_pop = 1'b1; step(); pix_pop = 1'b0; step();
    end
    chk("t6_restart_pix", exp_pix.size(), 0);
    chk("t6_underrun_end", underrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
